fft_inpl_frame_ctrl: RTL
========================

Name: fft_inpl_frame_ctrl

Overview:
- Frame sequencer between a streaming sample source/sink and the in-place FFT core.
- Input side: gates source samples into the core only while it is loading, counts exactly POINTS samples per frame and detects aborted loads.
- Output side: issues the read-out request, counts result samples, tags them with frame ID / last / scale exponent, and flags protocol errors.

Parameters:
- POINTS, 256, FFT length; power of two, 16..4096.
- WIDTH, 18, sample component width.
- EXPW, 4, SCALE_EXP width; equals floor_log2(log2(POINTS))+1.
- IDW, 4, frame ID width; wraps modulo 2^IDW.
- TIMEOUT, 64, max cycles from FFT_READ_OUTP to first FFT_DATAO_VALID.

Ports:
- CLK  in  1  clock.
- NGRST  in  1  synchronous active-low reset.
- ENABLE  in  1  when low, no new input or output frame is started.
- CLR_STATUS  in  1  one-cycle pulse; clears sticky error flags.
- S_VALID  in  1  source sample valid.
- S_READY  out  1  controller accepts a sample.
- S_RE, S_IM  in  WIDTH  source sample.
- FFT_DATAI_RE, FFT_DATAI_IM  out  WIDTH  to core.
- FFT_DATAI_VALID  out  1  to core.
- FFT_BUF_READY  in  1  core input buffer is loading.
- FFT_OUTP_READY  in  1  core has a result frame.
- FFT_READ_OUTP  out  1  read-out request pulse.
- FFT_DATAO_VALID  in  1  core result valid.
- FFT_DATAO_RE, FFT_DATAO_IM  in  WIDTH  core result.
- FFT_SCALE_EXP  in  EXPW  core scale exponent.
- M_READY  in  1  sink can take a whole frame (sampled only at frame start).
- M_VALID, M_LAST  out  1  result valid; last sample of frame.
- M_RE, M_IM  out  WIDTH  result data.
- M_FRAME_ID  out  IDW  result frame ID.
- M_SCALE_EXP  out  EXPW  result scale exponent.
- LOAD_ERR, TIMEOUT_ERR, UNEXP_ERR  out  1  sticky error flags.

Behaviour:
- Reset: one clock, synchronous, active-low, on CLK. While NGRST is low, all outputs, counters, frame IDs and flags are 0 and both FSMs go to IDLE. Reset mid-frame discards the partial frame with no error.
- Input FSM states: I_IDLE, I_LOAD, I_HOLD.
  - I_IDLE -> I_LOAD when ENABLE & FFT_BUF_READY; in_cnt=0.
  - I_LOAD: S_READY = FFT_BUF_READY. A transfer is S_VALID & S_READY.
  - Each transfer registers S_RE/S_IM onto FFT_DATAI_* with FFT_DATAI_VALID=1 one cycle later (latency 1) and increments in_cnt. Gaps are allowed.
  - Transfer with in_cnt==POINTS-1 -> I_HOLD; in_frame_id increments modulo 2^IDW.
  - FFT_BUF_READY falls while in I_LOAD with in_cnt<POINTS: LOAD_ERR=1, in_cnt=0, -> I_IDLE. Samples in that frame are lost.
  - I_HOLD: S_READY=0 until FFT_BUF_READY is sampled low, then -> I_IDLE. This prevents the next frame from starting in the same buffer window.
  - ENABLE going low mid-load does not stop the current frame.
- Output FSM states: O_IDLE, O_WAIT, O_STREAM.
  - O_IDLE -> O_WAIT when ENABLE & FFT_OUTP_READY & M_READY. In that cycle: FFT_READ_OUTP=1 for exactly 1 cycle, FFT_SCALE_EXP is latched to M_SCALE_EXP, tmo_cnt=0.
  - O_WAIT: the first FFT_DATAO_VALID -> O_STREAM and counts as sample 0.
  - O_WAIT: tmo_cnt reaching TIMEOUT-1 with no valid: TIMEOUT_ERR=1, -> O_IDLE.
  - O_STREAM: each FFT_DATAO_VALID increments out_cnt. On out_cnt==POINTS-1: M_LAST=1, out_frame_id increments, -> O_IDLE.
  - M_* are registered: FFT_DATAO_VALID at cycle n gives M_VALID at n+1. M_READY is not rechecked mid-frame; the frame is non-stallable.
  - FFT_DATAO_VALID seen in O_IDLE: UNEXP_ERR=1, data dropped, M_VALID stays 0.
  - FFT_DATAO_VALID in the same cycle as the timeout: counts as a valid sample; no error.
- M_FRAME_ID = out_frame_id, held constant for the whole frame.
- Error flags: set has priority over a same-cycle CLR_STATUS. Flags otherwise clear only on CLR_STATUS or reset.
- The input and output FSMs are independent. Simultaneous load and read-out is legal.

Decomposition:
- Package fft_inpl_frame_pkg: input/output state encodings, clog2 function, CNTW = log2(POINTS).
- Sub-module fft_inpl_frame_cnt: a wrapping counter with clr/en/terminal-count output. Instantiated for in_cnt, out_cnt and tmo_cnt.

Test Plan:
- POINTS=16, BUF_READY held high, 16 back-to-back S_VALID -> 16 FFT_DATAI_VALID pulses, each 1 cycle after its transfer; S_READY low from sample 16 until BUF_READY drops; in_frame_id 0 -> 1.
- BUF_READY drops after 9 samples -> LOAD_ERR=1, the next frame restarts at count 0; CLR_STATUS then clears LOAD_ERR.
- OUTP_READY=1, M_READY=1, core returns 16 valids 5 cycles after request -> exactly one READ_OUTP pulse, 16 M_VALID each 1 cycle later, M_LAST only on the 16th, M_SCALE_EXP = value at request, M_FRAME_ID=0.
- OUTP_READY=1, M_READY=0 for 20 cycles -> no READ_OUTP; M_READY rises -> READ_OUTP on the next cycle.
- TIMEOUT=64, no DATAO_VALID after request -> TIMEOUT_ERR=1 at cycle 64, FSM back to O_IDLE; a stray DATAO_VALID afterwards -> UNEXP_ERR=1, M_VALID stays 0.
- NGRST low mid-load (sample 7) and mid-stream (sample 10) -> all outputs 0 next cycle; a clean full frame afterwards completes with no flags set.

Source files
------------

// File: rtl/fft_inpl_frame_pkg.sv
// fft_inpl_frame_pkg: state encodings and width helpers shared by the FFT frame controller
package fft_inpl_frame_pkg;
    typedef enum logic [1:0] {I_IDLE, I_LOAD, I_HOLD} in_state_e;
    typedef enum logic [1:0] {O_IDLE, O_WAIT, O_STREAM} out_state_e;
    localparam int DEF_POINTS = 256;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction
    localparam int CNTW = clog2(DEF_POINTS);
endpackage

// File: rtl/fft_inpl_frame_cnt.sv
// fft_inpl_frame_cnt: wrapping 0..MAX-1 counter with synchronous clear and terminal-count flag
module fft_inpl_frame_cnt
#(
    parameter int W   = 8,
    parameter int MAX = 256
) (
    input  logic clk_i,
    input  logic ngrst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    logic [W-1:0] cnt_q, cnt_d;
    assign tc_o = cnt_q == W'(MAX - 1);
    always_comb cnt_d = clr_i ? '0 : en_i ? (tc_o ? '0 : cnt_q + 1'b1) : cnt_q;
    always_ff @(posedge clk_i) cnt_q <= ngrst_i ? cnt_d : '0;
endmodule

// File: rtl/fft_inpl_frame_ctrl.sv
// fft_inpl_frame_ctrl: frames source samples into the in-place FFT core and tags its result stream
module fft_inpl_frame_ctrl
    import fft_inpl_frame_pkg::*;
#(
    parameter int POINTS  = 256,
    parameter int WIDTH   = 18,
    parameter int EXPW    = 4,
    parameter int IDW     = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             ngrst_i,
    input  logic             enable_i,
    input  logic             clr_status_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [WIDTH-1:0] s_re_i,
    input  logic [WIDTH-1:0] s_im_i,
    output logic [WIDTH-1:0] fft_datai_re_o,
    output logic [WIDTH-1:0] fft_datai_im_o,
    output logic             fft_datai_valid_o,
    input  logic             fft_buf_ready_i,
    input  logic             fft_outp_ready_i,
    output logic             fft_read_outp_o,
    input  logic             fft_datao_valid_i,
    input  logic [WIDTH-1:0] fft_datao_re_i,
    input  logic [WIDTH-1:0] fft_datao_im_i,
    input  logic [EXPW-1:0]  fft_scale_exp_i,
    input  logic             m_ready_i,
    output logic             m_valid_o,
    output logic             m_last_o,
    output logic [WIDTH-1:0] m_re_o,
    output logic [WIDTH-1:0] m_im_o,
    output logic [IDW-1:0]   m_frame_id_o,
    output logic [EXPW-1:0]  m_scale_exp_o,
    output logic             load_err_o,
    output logic             timeout_err_o,
    output logic             unexp_err_o
);
    localparam int CW = clog2(POINTS);
    localparam int TW = clog2(TIMEOUT);

    in_state_e        in_q, in_d;
    out_state_e       out_q, out_d;
    logic [IDW-1:0]   in_id_q, out_id_q, m_id_q;
    logic [WIDTH-1:0] di_re_q, di_im_q, m_re_q, m_im_q;
    logic [EXPW-1:0]  scale_q;
    logic             di_valid_q, read_q, m_valid_q, m_last_q;
    logic             load_err_q, tmo_err_q, unexp_err_q;
    logic             xfer, in_tc, in_done, load_abort;
    logic             start, accept, out_tc, tmo_tc, timeout, out_done;

    assign s_ready_o  = in_q == I_LOAD && fft_buf_ready_i;
    assign xfer       = s_ready_o && s_valid_i;
    assign in_done    = xfer && in_tc;
    assign load_abort = in_q == I_LOAD && !fft_buf_ready_i;

    always_comb begin
        in_d = in_q;
        case (in_q)
            I_IDLE:  in_d = enable_i && fft_buf_ready_i ? I_LOAD : I_IDLE;
            I_LOAD:  in_d = in_done ? I_HOLD : load_abort ? I_IDLE : I_LOAD;
            I_HOLD:  in_d = fft_buf_ready_i ? I_HOLD : I_IDLE;
            default: in_d = I_IDLE;
        endcase
    end

    assign start    = out_q == O_IDLE && enable_i && fft_outp_ready_i && m_ready_i;
    assign accept   = out_q != O_IDLE && fft_datao_valid_i;
    assign out_done = accept && out_tc;
    // a valid arriving on the timeout cycle wins over the timeout
    assign timeout  = out_q == O_WAIT && !fft_datao_valid_i && tmo_tc;

    always_comb begin
        out_d = out_q;
        case (out_q)
            O_IDLE:   out_d = start ? O_WAIT : O_IDLE;
            O_WAIT:   out_d = accept ? O_STREAM : timeout ? O_IDLE : O_WAIT;
            O_STREAM: out_d = out_done ? O_IDLE : O_STREAM;
            default:  out_d = O_IDLE;
        endcase
    end

    fft_inpl_frame_cnt #(.W(CW), .MAX(POINTS)) u_in_cnt (
        .clk_i(clk_i), .ngrst_i(ngrst_i), .clr_i(in_q != I_LOAD || load_abort), .en_i(xfer), .tc_o(in_tc)
    );
    fft_inpl_frame_cnt #(.W(CW), .MAX(POINTS)) u_out_cnt (
        .clk_i(clk_i), .ngrst_i(ngrst_i), .clr_i(out_q == O_IDLE), .en_i(accept), .tc_o(out_tc)
    );
    fft_inpl_frame_cnt #(.W(TW), .MAX(TIMEOUT)) u_tmo_cnt (
        .clk_i(clk_i), .ngrst_i(ngrst_i), .clr_i(out_q != O_WAIT), .en_i(1'b1), .tc_o(tmo_tc)
    );

    always_ff @(posedge clk_i) begin
        if (!ngrst_i) begin
            in_q        <= I_IDLE;
            out_q       <= O_IDLE;
            in_id_q     <= '0;
            out_id_q    <= '0;
            m_id_q      <= '0;
            di_re_q     <= '0;
            di_im_q     <= '0;
            m_re_q      <= '0;
            m_im_q      <= '0;
            scale_q     <= '0;
            di_valid_q  <= 1'b0;
            read_q      <= 1'b0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            load_err_q  <= 1'b0;
            tmo_err_q   <= 1'b0;
            unexp_err_q <= 1'b0;
        end else begin
            in_q        <= in_d;
            out_q       <= out_d;
            in_id_q     <= in_id_q + IDW'(in_done);
            out_id_q    <= out_id_q + IDW'(out_done);
            di_valid_q  <= xfer;
            read_q      <= start;
            m_valid_q   <= accept;
            m_last_q    <= out_done;
            if (xfer) begin
                di_re_q <= s_re_i;
                di_im_q <= s_im_i;
            end
            if (start) scale_q <= fft_scale_exp_i;
            // the tag is captured per sample so it stays on the old ID through M_LAST
            if (accept) begin
                m_re_q <= fft_datao_re_i;
                m_im_q <= fft_datao_im_i;
                m_id_q <= out_id_q;
            end
            load_err_q  <= load_abort || (load_err_q && !clr_status_i);
            tmo_err_q   <= timeout || (tmo_err_q && !clr_status_i);
            unexp_err_q <= (out_q == O_IDLE && fft_datao_valid_i) || (unexp_err_q && !clr_status_i);
        end
    end

    assign fft_datai_re_o    = di_re_q;
    assign fft_datai_im_o    = di_im_q;
    assign fft_datai_valid_o = di_valid_q;
    assign fft_read_outp_o   = read_q;
    assign m_valid_o         = m_valid_q;
    assign m_last_o          = m_last_q;
    assign m_re_o            = m_re_q;
    assign m_im_o            = m_im_q;
    assign m_frame_id_o      = m_id_q;
    assign m_scale_exp_o     = scale_q;
    assign load_err_o        = load_err_q;
    assign timeout_err_o     = tmo_err_q;
    assign unexp_err_o       = unexp_err_q;
endmodule
